// File: rtl/tcdm_rob.sv
// Reorder buffer between a core and a TCDM shim. Tracked requests (reads
// and AMOs) reserve a slot at issue and take the slot index as their ID.
// Responses may come back in any order. They are handed to the core
// strictly in issue order.
module tcdm_rob #(
   parameter int AddrWidth           = 32,
   parameter int DataWidth           = 32,
   parameter int MaxOutStandingReads = 8,
   localparam int StrbWidth          = DataWidth / 8,
   localparam int MetaIdWidth        = $clog2(MaxOutStandingReads)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   // core request
   input  logic [AddrWidth-1:0]   core_qaddr_i,
   input  logic                   core_qwrite_i,
   input  logic [3:0]             core_qamo_i,
   input  logic [DataWidth-1:0]   core_qdata_i,
   input  logic [StrbWidth-1:0]   core_qstrb_i,
   input  logic                   core_qlrwait_i,
   input  logic                   core_qvalid_i,
   output logic                   core_qready_o,
   // core response
   output logic [DataWidth-1:0]   core_pdata_o,
   output logic                   core_perror_o,
   output logic                   core_plrwait_o,
   output logic                   core_pvalid_o,
   input  logic                   core_pready_i,
   // shim request
   output logic [AddrWidth-1:0]   data_qaddr_o,
   output logic                   data_qwrite_o,
   output logic [3:0]             data_qamo_o,
   output logic [DataWidth-1:0]   data_qdata_o,
   output logic [StrbWidth-1:0]   data_qstrb_o,
   output logic [MetaIdWidth-1:0] data_qid_o,
   output logic                   data_qlrwait_o,
   output logic                   data_qvalid_o,
   input  logic                   data_qready_i,
   // shim response
   input  logic [DataWidth-1:0]   data_pdata_i,
   input  logic                   data_perror_i,
   input  logic [MetaIdWidth-1:0] data_pid_i,
   input  logic                   data_plrwait_i,
   input  logic                   data_pvalid_i,
   output logic                   data_pready_o
);

   localparam logic [MetaIdWidth-1:0] PtrOne    = MetaIdWidth'(1);
   localparam logic [MetaIdWidth:0]   CountOne  = (MetaIdWidth + 1)'(1);
   localparam logic [MetaIdWidth:0]   FullCount = (MetaIdWidth + 1)'(MaxOutStandingReads);

   logic [MetaIdWidth-1:0]         head_q, tail_q;
   logic [MetaIdWidth:0]           count_q;
   logic [MaxOutStandingReads-1:0] alloc_q, filled_q, err_q, lrwait_q;
   logic [DataWidth-1:0]           data_q [MaxOutStandingReads];

   logic tracked, full, issue_ok, do_alloc, do_fill, do_retire;

   // Issue gating: untracked writes always pass; tracked requests need a free slot.
   // Full is taken from the registered count. A retire in the same cycle therefore
   // does not unblock an allocation.
   always_comb begin
      tracked   = ~core_qwrite_i | (core_qamo_i != 4'd0);
      full      = (count_q == FullCount);
      issue_ok  = ~tracked | ~full;
      do_alloc  = core_qvalid_i & issue_ok & data_qready_i & tracked;
      do_fill   = data_pvalid_i & alloc_q[data_pid_i] & ~filled_q[data_pid_i];
      do_retire = filled_q[head_q] & core_pready_i;
   end

   // Requests pass through to the shim. The ID is the reserved slot for tracked requests.
   always_comb begin
      data_qaddr_o   = core_qaddr_i;
      data_qwrite_o  = core_qwrite_i;
      data_qamo_o    = core_qamo_i;
      data_qdata_o   = core_qdata_i;
      data_qstrb_o   = core_qstrb_i;
      data_qlrwait_o = core_qlrwait_i;
      data_qid_o     = tracked ? tail_q : '0;
      data_qvalid_o  = core_qvalid_i & issue_ok;
      core_qready_o  = data_qready_i & issue_ok;
      data_pready_o  = 1'b1;
   end

   // The head slot drives the core response directly from registers.
   always_comb begin
      core_pvalid_o  = filled_q[head_q];
      core_pdata_o   = data_q[head_q];
      core_perror_o  = err_q[head_q];
      core_plrwait_o = lrwait_q[head_q];
   end

   // Slot bookkeeping. Allocate, fill and retire never hit the same slot in one
   // cycle, so the three updates are independent.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         alloc_q  <= '0;
         filled_q <= '0;
         err_q    <= '0;
         lrwait_q <= '0;
         for (int i = 0; i < MaxOutStandingReads; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         if (do_alloc) begin
            alloc_q[tail_q]  <= 1'b1;
            filled_q[tail_q] <= 1'b0;
            tail_q           <= tail_q + PtrOne;
         end
         if (do_fill) begin
            filled_q[data_pid_i] <= 1'b1;
            data_q[data_pid_i]   <= data_pdata_i;
            err_q[data_pid_i]    <= data_perror_i;
            lrwait_q[data_pid_i] <= data_plrwait_i;
         end
         if (do_retire) begin
            alloc_q[head_q]  <= 1'b0;
            filled_q[head_q] <= 1'b0;
            head_q           <= head_q + PtrOne;
         end
         if (do_alloc && !do_retire) begin
            count_q <= count_q + CountOne;
         end else if (!do_alloc && do_retire) begin
            count_q <= count_q - CountOne;
         end
      end
   end

endmodule
